// File: rtl/sram_stats_pkg.sv
// Shared types and constants for the flow-statistics SRAM scheduler.
// SRAM_STATS_SAT_EN: when defined, counter adds saturate instead of wrapping.
package sram_stats_pkg;

    localparam int unsigned MEM_WIDTH      = 36;
    localparam int unsigned NUM_MEM_INPUTS = 6;
    localparam int unsigned NUM_MEM_CHIPS  = 3;
    localparam int unsigned MEM_ADDR_WIDTH = 19;
    localparam int unsigned CNT_ADDR_WIDTH = 11;
    localparam int unsigned PEND_DEPTH     = 8;

    localparam int unsigned WORD_W      = MEM_WIDTH * NUM_MEM_INPUTS;
    localparam int unsigned PEND_PTR_W  = $clog2(PEND_DEPTH);
    localparam int unsigned CNT_W       = 32;
    localparam int unsigned UPD_BYTES_W = 16;

    // Counter word layout inside the SRAM word
    localparam int unsigned PKTS_LSB  = 0;
    localparam int unsigned PKTS_MSB  = 31;
    localparam int unsigned BYTES_LSB = 32;
    localparam int unsigned BYTES_MSB = 63;

    typedef enum logic [1:0] {
        OP_UPD = 2'd0,
        OP_RD  = 2'd1,
        OP_CLR = 2'd2
    } op_e;

    typedef enum logic [1:0] {
        ST_WAIT_CAL = 2'd0,
        ST_CLEAR    = 2'd1,
        ST_RUN      = 2'd2
    } state_e;

    typedef struct packed {
        op_e                        op;
        logic [CNT_ADDR_WIDTH-1:0]  addr;
        logic [UPD_BYTES_W-1:0]     bytes;
    } pend_entry_t;

    function automatic logic [CNT_W-1:0] cnt_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
`ifdef SRAM_STATS_SAT_EN
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
`else
        return a + b;
`endif
    endfunction

endpackage

// File: rtl/sram_stats_pend_q.sv
// In-order queue of outstanding SRAM reads, with a per-entry address match
// vector against two candidate request addresses for hazard detection.
module sram_stats_pend_q
    import sram_stats_pkg::*;
(
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  pend_entry_t                push_entry,
    input  logic                       pop,
    output pend_entry_t                head,
    output logic                       full,
    output logic                       empty,
    input  logic [CNT_ADDR_WIDTH-1:0]  cmp_addr_a,
    input  logic [CNT_ADDR_WIDTH-1:0]  cmp_addr_b,
    output logic [PEND_DEPTH-1:0]      match_a,
    output logic [PEND_DEPTH-1:0]      match_b
);

    localparam int unsigned OCC_W = PEND_PTR_W + 1;

    pend_entry_t             mem_q [PEND_DEPTH];
    pend_entry_t             mem_d [PEND_DEPTH];
    logic [PEND_DEPTH-1:0]   vld_q, vld_d;
    logic [PEND_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PEND_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]        cnt_q, cnt_d;
    logic                    do_push, do_pop;

    always_comb begin
        do_push  = push && (cnt_q != OCC_W'(PEND_DEPTH));
        do_pop   = pop && (cnt_q != '0);
        mem_d    = mem_q;
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_entry;
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = wr_ptr_q + PEND_PTR_W'(1);
        end
        if (do_pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PEND_PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + OCC_W'(1);
            2'b01:   cnt_d = cnt_q - OCC_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Live entries compared in parallel; an entry being popped still counts
    always_comb begin
        match_a = '0;
        match_b = '0;
        for (int i = 0; i < int'(PEND_DEPTH); i++) begin
            match_a[i] = vld_q[i] && (mem_q[i].addr == cmp_addr_a);
            match_b[i] = vld_q[i] && (mem_q[i].addr == cmp_addr_b);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (cnt_q == OCC_W'(PEND_DEPTH));
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/sram_stats_arb.sv
// Clears the stats SRAM after calibration, then arbitrates hazard-free
// packet-update RMWs and host read / read-and-clear. Honours SRAM_STATS_SAT_EN.
module sram_stats_arb
    import sram_stats_pkg::*;
(
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       cal_done,
    output logic                       init_done,
    input  logic                       upd_valid,
    output logic                       upd_ready,
    input  logic [CNT_ADDR_WIDTH-1:0]  upd_addr,
    input  logic [UPD_BYTES_W-1:0]     upd_bytes,
    input  logic                       host_req_valid,
    output logic                       host_req_ready,
    input  logic [CNT_ADDR_WIDTH-1:0]  host_req_addr,
    input  logic                       host_req_clr,
    output logic                       host_rsp_valid,
    output logic [CNT_W-1:0]           host_rsp_pkts,
    output logic [CNT_W-1:0]           host_rsp_bytes,
    input  logic                       sram_read_full,
    input  logic                       sram_write_full,
    output logic                       din_ready,
    output logic [MEM_ADDR_WIDTH-1:0]  din_addr,
    input  logic [WORD_W-1:0]          din,
    input  logic [NUM_MEM_CHIPS-1:0]   din_valid,
    output logic                       dout_burst_ready,
    output logic [MEM_ADDR_WIDTH-1:0]  dout_addr,
    output logic [WORD_W-1:0]          dout
);

    state_e                     state_q, state_d;
    logic [CNT_ADDR_WIDTH-1:0]  clr_addr_q, clr_addr_d;
    logic                       rr_q, rr_d;
    logic                       init_done_q, init_done_d;
    logic                       din_ready_q, din_ready_d;
    logic [MEM_ADDR_WIDTH-1:0]  din_addr_q, din_addr_d;
    logic                       dout_burst_ready_q, dout_burst_ready_d;
    logic [MEM_ADDR_WIDTH-1:0]  dout_addr_q, dout_addr_d;
    logic [WORD_W-1:0]          dout_q, dout_d;
    logic                       host_rsp_valid_q, host_rsp_valid_d;
    logic [CNT_W-1:0]           host_rsp_pkts_q, host_rsp_pkts_d;
    logic [CNT_W-1:0]           host_rsp_bytes_q, host_rsp_bytes_d;
    logic                       wb_valid_q, wb_valid_d;
    logic [CNT_ADDR_WIDTH-1:0]  wb_addr_q, wb_addr_d;

    pend_entry_t                push_entry, head;
    logic                       q_full, q_empty;
    logic [PEND_DEPTH-1:0]      match_upd, match_host;
    logic                       issue_ok, elig_upd, elig_host;
    logic                       grant_upd, grant_host, resp;
    logic [CNT_W-1:0]           old_pkts, old_bytes;
    logic                       unused_din_hi;

    sram_stats_pend_q u_pend_q (
        .clk        (clk),
        .resetn     (resetn),
        .push       (grant_upd | grant_host),
        .push_entry (push_entry),
        .pop        (resp),
        .head       (head),
        .full       (q_full),
        .empty      (q_empty),
        .cmp_addr_a (upd_addr),
        .cmp_addr_b (host_req_addr),
        .match_a    (match_upd),
        .match_b    (match_host)
    );

    // Eligibility and round-robin grant; rr_q = 1 favours the host
    always_comb begin
        issue_ok  = (state_q == ST_RUN) && !q_full && !sram_read_full && !sram_write_full;
        elig_upd  = issue_ok && upd_valid && !(|match_upd)
                    && !(wb_valid_q && (wb_addr_q == upd_addr));
        elig_host = issue_ok && host_req_valid && !(|match_host)
                    && !(wb_valid_q && (wb_addr_q == host_req_addr));
        grant_upd  = elig_upd && (!elig_host || !rr_q);
        grant_host = elig_host && !grant_upd;
        if (grant_upd) begin
            push_entry = '{op: OP_UPD, addr: upd_addr, bytes: upd_bytes};
        end else begin
            push_entry = '{op: (host_req_clr ? OP_CLR : OP_RD), addr: host_req_addr, bytes: '0};
        end
        resp      = (&din_valid) && !q_empty;
        old_pkts  = din[PKTS_MSB:PKTS_LSB];
        old_bytes = din[BYTES_MSB:BYTES_LSB];
    end

    assign unused_din_hi = ^din[WORD_W-1:BYTES_MSB+1];

    always_comb begin
        state_d            = state_q;
        clr_addr_d         = clr_addr_q;
        rr_d               = rr_q;
        init_done_d        = (state_q == ST_RUN);
        din_ready_d        = 1'b0;
        din_addr_d         = din_addr_q;
        dout_burst_ready_d = 1'b0;
        dout_addr_d        = dout_addr_q;
        dout_d             = dout_q;
        host_rsp_valid_d   = 1'b0;
        host_rsp_pkts_d    = host_rsp_pkts_q;
        host_rsp_bytes_d   = host_rsp_bytes_q;
        wb_valid_d         = 1'b0;
        wb_addr_d          = wb_addr_q;

        case (state_q)
            ST_WAIT_CAL: begin
                if (cal_done) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (!sram_write_full) begin
                    dout_burst_ready_d = 1'b1;
                    dout_addr_d        = MEM_ADDR_WIDTH'(clr_addr_q);
                    dout_d             = '0;
                    clr_addr_d         = clr_addr_q + CNT_ADDR_WIDTH'(1);
                    if (clr_addr_q == '1) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (grant_upd || grant_host) begin
                    din_ready_d = 1'b1;
                    din_addr_d  = MEM_ADDR_WIDTH'(push_entry.addr);
                    rr_d        = grant_upd;
                end
                // Write-back register keeps the address visible to hazard checks next cycle
                if (resp) begin
                    wb_valid_d  = 1'b1;
                    wb_addr_d   = head.addr;
                    dout_addr_d = MEM_ADDR_WIDTH'(head.addr);
                    case (head.op)
                        OP_UPD: begin
                            dout_burst_ready_d              = 1'b1;
                            dout_d                          = '0;
                            dout_d[PKTS_MSB:PKTS_LSB]   = cnt_add(old_pkts, CNT_W'(1));
                            dout_d[BYTES_MSB:BYTES_LSB] = cnt_add(old_bytes, CNT_W'(head.bytes));
                        end
                        OP_CLR: begin
                            dout_burst_ready_d = 1'b1;
                            dout_d             = '0;
                            host_rsp_valid_d   = 1'b1;
                            host_rsp_pkts_d    = old_pkts;
                            host_rsp_bytes_d   = old_bytes;
                        end
                        default: begin
                            host_rsp_valid_d = 1'b1;
                            host_rsp_pkts_d  = old_pkts;
                            host_rsp_bytes_d = old_bytes;
                        end
                    endcase
                end
            end
            default: state_d = ST_WAIT_CAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q            <= ST_WAIT_CAL;
            clr_addr_q         <= '0;
            rr_q               <= 1'b0;
            init_done_q        <= 1'b0;
            din_ready_q        <= 1'b0;
            din_addr_q         <= '0;
            dout_burst_ready_q <= 1'b0;
            dout_addr_q        <= '0;
            dout_q             <= '0;
            host_rsp_valid_q   <= 1'b0;
            host_rsp_pkts_q    <= '0;
            host_rsp_bytes_q   <= '0;
            wb_valid_q         <= 1'b0;
            wb_addr_q          <= '0;
        end else begin
            state_q            <= state_d;
            clr_addr_q         <= clr_addr_d;
            rr_q               <= rr_d;
            init_done_q        <= init_done_d;
            din_ready_q        <= din_ready_d;
            din_addr_q         <= din_addr_d;
            dout_burst_ready_q <= dout_burst_ready_d;
            dout_addr_q        <= dout_addr_d;
            dout_q             <= dout_d;
            host_rsp_valid_q   <= host_rsp_valid_d;
            host_rsp_pkts_q    <= host_rsp_pkts_d;
            host_rsp_bytes_q   <= host_rsp_bytes_d;
            wb_valid_q         <= wb_valid_d;
            wb_addr_q          <= wb_addr_d;
        end
    end

    assign upd_ready        = grant_upd;
    assign host_req_ready   = grant_host;
    assign init_done        = init_done_q;
    assign din_ready        = din_ready_q;
    assign din_addr         = din_addr_q;
    assign dout_burst_ready = dout_burst_ready_q;
    assign dout_addr        = dout_addr_q;
    assign dout             = dout_q;
    assign host_rsp_valid   = host_rsp_valid_q;
    assign host_rsp_pkts    = host_rsp_pkts_q;
    assign host_rsp_bytes   = host_rsp_bytes_q;

endmodule

// File: tb/tb_sram_stats_arb.sv
// Scoreboard bench for sram_stats_arb with a 4-cycle-latency SRAM model.
module tb_sram_stats_arb;
    import sram_stats_pkg::*;

`ifdef SRAM_STATS_SAT_EN
    localparam logic [31:0] OVF_EXP = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] OVF_EXP = 32'h0000_0010;
`endif

    logic                       clk = 1'b0;
    logic                       resetn, cal_done, init_done;
    logic                       upd_valid, upd_ready;
    logic [CNT_ADDR_WIDTH-1:0]  upd_addr;
    logic [UPD_BYTES_W-1:0]     upd_bytes;
    logic                       host_req_valid, host_req_ready, host_req_clr;
    logic [CNT_ADDR_WIDTH-1:0]  host_req_addr;
    logic                       host_rsp_valid;
    logic [31:0]                host_rsp_pkts, host_rsp_bytes;
    logic                       sram_read_full, sram_write_full;
    logic                       din_ready;
    logic [MEM_ADDR_WIDTH-1:0]  din_addr;
    logic [WORD_W-1:0]          din;
    logic [NUM_MEM_CHIPS-1:0]   din_valid;
    logic                       dout_burst_ready;
    logic [MEM_ADDR_WIDTH-1:0]  dout_addr;
    logic [WORD_W-1:0]          dout;

    always #5 clk = ~clk;

    sram_stats_arb dut (
        .clk(clk), .resetn(resetn), .cal_done(cal_done), .init_done(init_done),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_addr(upd_addr), .upd_bytes(upd_bytes),
        .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
        .host_req_addr(host_req_addr), .host_req_clr(host_req_clr),
        .host_rsp_valid(host_rsp_valid), .host_rsp_pkts(host_rsp_pkts), .host_rsp_bytes(host_rsp_bytes),
        .sram_read_full(sram_read_full), .sram_write_full(sram_write_full),
        .din_ready(din_ready), .din_addr(din_addr), .din(din), .din_valid(din_valid),
        .dout_burst_ready(dout_burst_ready), .dout_addr(dout_addr), .dout(dout)
    );

    typedef struct { logic [10:0] addr; logic [31:0] p; logic [31:0] b; } wr_t;
    typedef struct { logic [31:0] p; logic [31:0] b; } rsp_t;
    typedef struct { logic [63:0] data; int unsigned due; } rd_t;

    wr_t          exp_wr[$];
    rsp_t         exp_rsp[$];
    rd_t          rd_pipe[$];
    byte          grant_log[$];
    int unsigned  rd7_cyc[$];
    int unsigned  wr7_cyc[$];

    logic [63:0]  mem [2048];
    logic [31:0]  ref_p [2048];
    logic [31:0]  ref_b [2048];

    int unsigned  cyc = 0;
    int           n_checks = 0;
    int           n_errors = 0;
    int           clr_exp = 0;
    int unsigned  last_clr_cyc = 0;
    bit           clr_done_seen = 1'b0;
    wr_t          mw;
    rsp_t         mr;
    rd_t          md;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] sadd(input logic [31:0] a, input logic [31:0] b);
`ifdef SRAM_STATS_SAT_EN
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
`else
        return a + b;
`endif
    endfunction

    // SRAM model and output monitor
    always @(negedge clk) begin
        din_valid = '0;
        din       = '0;
        if (resetn) begin
            if (dout_burst_ready) begin
                if (!clr_done_seen) begin
                    chk("clr_addr", 64'(dout_addr), 64'(clr_exp));
                    chk("clr_data", 64'(dout != '0), 64'd0);
                    if (clr_exp == 2047) last_clr_cyc = cyc;
                    clr_exp++;
                end else begin
                    if (exp_wr.size() == 0) begin
                        chk("wr_unexpected", 64'(dout_addr), 64'h7FFFF_FFFF);
                    end else begin
                        mw = exp_wr.pop_front();
                        chk("wr_addr", 64'(dout_addr), 64'(mw.addr));
                        chk("wr_word", dout[63:0], {mw.b, mw.p});
                        chk("wr_upper", 64'(|dout[WORD_W-1:64]), 64'd0);
                    end
                    if (dout_addr == 19'd7) wr7_cyc.push_back(cyc);
                end
                mem[dout_addr[10:0]] = dout[63:0];
            end
            if (din_ready) begin
                md.data = mem[din_addr[10:0]];
                md.due  = cyc + 4;
                rd_pipe.push_back(md);
                if (din_addr == 19'd7) rd7_cyc.push_back(cyc);
            end
            if (rd_pipe.size() > 0 && rd_pipe[0].due == cyc) begin
                md = rd_pipe.pop_front();
                din[63:0] = md.data;
                din_valid = '1;
            end
            if (host_rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    chk("rsp_unexpected", {host_rsp_bytes, host_rsp_pkts}, 64'hDEAD_DEAD_DEAD_DEAD);
                end else begin
                    mr = exp_rsp.pop_front();
                    chk("rsp_pkts", 64'(host_rsp_pkts), 64'(mr.p));
                    chk("rsp_bytes", 64'(host_rsp_bytes), 64'(mr.b));
                end
            end
            if (init_done && !clr_done_seen) begin
                clr_done_seen = 1'b1;
                chk("init_done_lat", 64'(cyc), 64'(last_clr_cyc + 1));
            end
        end
    end

    // Called at a negedge; returns at the negedge after acceptance with valid dropped
    task automatic do_upd(input logic [10:0] a, input logic [15:0] b);
        int n = 0;
        upd_valid = 1'b1; upd_addr = a; upd_bytes = b;
        #1;
        while (!upd_ready && n < 200) begin
            @(negedge clk); #1; n++;
        end
        if (!upd_ready) begin
            chk("upd_timeout", 64'd0, 64'd1);
        end else begin
            ref_p[a] = sadd(ref_p[a], 32'd1);
            ref_b[a] = sadd(ref_b[a], 32'(b));
            exp_wr.push_back('{a, ref_p[a], ref_b[a]});
            grant_log.push_back(8'h55);
        end
        @(negedge clk);
        upd_valid = 1'b0;
    endtask

    task automatic do_host(input logic [10:0] a, input logic clr);
        int n = 0;
        host_req_valid = 1'b1; host_req_addr = a; host_req_clr = clr;
        #1;
        while (!host_req_ready && n < 200) begin
            @(negedge clk); #1; n++;
        end
        if (!host_req_ready) begin
            chk("host_timeout", 64'd0, 64'd1);
        end else begin
            exp_rsp.push_back('{ref_p[a], ref_b[a]});
            if (clr) begin
                ref_p[a] = '0; ref_b[a] = '0;
                exp_wr.push_back('{a, 32'd0, 32'd0});
            end
            grant_log.push_back(8'h48);
        end
        @(negedge clk);
        host_req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_wr.size() != 0 || exp_rsp.size() != 0 || rd_pipe.size() != 0) && n < 200) begin
            @(negedge clk); n++;
        end
        if (n >= 200) chk("drain_timeout", 64'(exp_wr.size() + exp_rsp.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 2048; i++) begin
            mem[i] = 64'hA5A5_A5A5_A5A5_A5A5; ref_p[i] = '0; ref_b[i] = '0;
        end
        resetn = 1'b0; cal_done = 1'b0;
        upd_valid = 1'b0; upd_addr = '0; upd_bytes = '0;
        host_req_valid = 1'b0; host_req_addr = '0; host_req_clr = 1'b0;
        sram_read_full = 1'b0; sram_write_full = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_din_ready", 64'(din_ready), 64'd0);
        chk("rst_dout_wr", 64'(dout_burst_ready), 64'd0);
        chk("rst_rsp_valid", 64'(host_rsp_valid), 64'd0);
        chk("rst_dout_addr", 64'(dout_addr), 64'd0);
        resetn = 1'b1;
        upd_valid = 1'b1; host_req_valid = 1'b1;
        #1;
        chk("wait_upd_ready", 64'(upd_ready), 64'd0);
        chk("wait_host_ready", 64'(host_req_ready), 64'd0);
        @(negedge clk);
        upd_valid = 1'b0; host_req_valid = 1'b0;

        while (cyc < 10) @(negedge clk);
        cal_done = 1'b1;
        n = 0;
        while (clr_exp < 1000 && n < 3000) begin @(negedge clk); n++; end
        sram_write_full = 1'b1;
        repeat (3) @(negedge clk);
        sram_write_full = 1'b0;
        n = 0;
        while (!clr_done_seen && n < 3000) begin @(negedge clk); n++; end
        chk("clr_done", 64'(clr_done_seen), 64'd1);
        chk("clr_count", 64'(clr_exp), 64'd2048);

        mem[3] = {32'd1500, 32'd10};        ref_p[3] = 32'd10; ref_b[3] = 32'd1500;
        mem[9] = {32'hFFFF_FFF0, 32'd0};    ref_p[9] = 32'd0;  ref_b[9] = 32'hFFFF_FFF0;

        @(negedge clk);
        sram_read_full = 1'b1; upd_valid = 1'b1; upd_addr = 11'd20; upd_bytes = 16'd1;
        #1;
        chk("rdfull_block0", 64'(upd_ready), 64'd0);
        @(negedge clk); #1;
        chk("rdfull_block1", 64'(upd_ready), 64'd0);
        @(negedge clk);
        upd_valid = 1'b0; sram_read_full = 1'b0;

        @(negedge clk);
        do_upd(11'd5, 16'd64);
        drain();
        chk("upd5_word", mem[5], {32'd64, 32'd1});

        rd7_cyc.delete(); wr7_cyc.delete();
        do_upd(11'd7, 16'd100);
        do_upd(11'd7, 16'd200);
        drain();
        chk("haz_rd_cnt", 64'(rd7_cyc.size()), 64'd2);
        chk("haz_wr_cnt", 64'(wr7_cyc.size()), 64'd2);
        if (rd7_cyc.size() == 2 && wr7_cyc.size() == 2)
            chk("haz_order", 64'(rd7_cyc[1] > wr7_cyc[0]), 64'd1);
        chk("haz_word", mem[7], {32'd300, 32'd2});

        grant_log.delete();
        fork
            begin
                for (int k = 0; k < 4; k++) do_upd(11'(100 + k), 16'(10 + k));
            end
            begin
                for (int k = 0; k < 4; k++) do_host(11'(200 + k), 1'b0);
            end
        join
        drain();
        chk("arb_grants", 64'(grant_log.size()), 64'd8);
        for (int i = 1; i < grant_log.size(); i++)
            chk("arb_alt", 64'(grant_log[i] != grant_log[i-1]), 64'd1);

        do_host(11'd3, 1'b1);
        do_host(11'd3, 1'b0);
        drain();
        chk("clr3_word", mem[3], 64'd0);

        do_upd(11'd9, 16'd32);
        drain();
        chk("ovf_bytes", 64'(mem[9][63:32]), 64'(OVF_EXP));
        chk("ovf_pkts", 64'(mem[9][31:0]), 64'd1);
        do_host(11'd9, 1'b0);
        do_host(11'd7, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
